// File: rtl/stream_to_mem_arb.sv
// Round-robin arbiter of NumPorts request streams onto one memory port; responses come back
// in issue order via a fall-through response FIFO and an ID FIFO. Optional perf counters: STREAM_TO_MEM_ARB_PERF_EN.
module stream_to_mem_arb #(
    parameter int NumPorts  = 2,
    parameter int ReqWidth  = 64,
    parameter int RespWidth = 32,
    parameter int BufDepth  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumPorts*ReqWidth-1:0] req_i,
    input  logic [NumPorts-1:0]          req_valid_i,
    output logic [NumPorts-1:0]          req_ready_o,
    output logic [RespWidth-1:0]         resp_o,
    output logic [NumPorts-1:0]          resp_valid_o,
    input  logic [NumPorts-1:0]          resp_ready_i,
    output logic [ReqWidth-1:0]          mem_req_o,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    input  logic [RespWidth-1:0]         mem_resp_i,
    input  logic                         mem_resp_valid_i,
    output logic                         resp_lost_o,
    output logic [31:0]                  perf_issued_o,
    output logic [31:0]                  perf_stall_o
);
    localparam int IdW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int CntW = $clog2(BufDepth + 1) + 1;

    typedef logic [IdW-1:0]  id_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    logic [NumPorts-1:0][ReqWidth-1:0] req_arr;
    assign req_arr = req_i;

    cnt_t cnt_q, rcnt_q;
    id_t  rr_q, held_q, gnt, id_head;
    logic lock_q;
    id_t  id_mem [BufDepth];
    ptr_t id_wr_q, id_rd_q;
    logic [RespWidth-1:0] rsp_mem [BufDepth];
    ptr_t rs_wr_q, rs_rd_q;

    logic can_issue, hs, pop, rsp_empty, rsp_full, rsp_avail, rsp_push, rsp_pop;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(BufDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan offsets high to low so the valid port closest to rr_q is the last (winning) write.
    always_comb begin : arb_c
        int  k;
        id_t idx;
        k   = 0;
        idx = '0;
        gnt = rr_q;
        if (lock_q) begin
            gnt = held_q;
        end else begin
            for (int i = NumPorts - 1; i >= 0; i--) begin
                k = int'(rr_q) + i;
                if (k >= NumPorts) k = k - NumPorts;
                idx = id_t'(k);
                if (req_valid_i[idx]) gnt = idx;
            end
        end
    end

    assign rsp_empty = (rcnt_q == '0);
    assign rsp_full  = (rcnt_q == cnt_t'(BufDepth));
    // A response with nothing outstanding is stale (e.g. issued before a reset) and never surfaces.
    assign rsp_avail = !rsp_empty || (mem_resp_valid_i && (cnt_q != '0));
    assign id_head   = id_mem[id_rd_q];
    assign resp_o    = rsp_empty ? mem_resp_i : rsp_mem[rs_rd_q];

    always_comb begin
        resp_valid_o          = '0;
        resp_valid_o[id_head] = rsp_avail;
    end

    assign pop             = |(resp_valid_o & resp_ready_i);
    assign can_issue       = (cnt_q < cnt_t'(BufDepth)) || pop;
    assign mem_req_valid_o = (|req_valid_i) && can_issue;
    assign mem_req_o       = req_arr[gnt];
    assign hs              = mem_req_valid_o && mem_req_ready_i;

    always_comb begin
        req_ready_o      = '0;
        req_ready_o[gnt] = mem_req_ready_i && can_issue;
    end

    assign rsp_pop  = pop && !rsp_empty;
    assign rsp_push = mem_resp_valid_i && !rsp_full && (cnt_q != '0) && !(pop && rsp_empty);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            rcnt_q      <= '0;
            rr_q        <= '0;
            held_q      <= '0;
            lock_q      <= 1'b0;
            id_wr_q     <= '0;
            id_rd_q     <= '0;
            rs_wr_q     <= '0;
            rs_rd_q     <= '0;
            resp_lost_o <= 1'b0;
        end else begin
            case ({hs, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
            if (hs) begin
                lock_q  <= 1'b0;
                rr_q    <= (gnt == id_t'(NumPorts - 1)) ? '0 : gnt + 1'b1;
                id_wr_q <= ptr_inc(id_wr_q);
            end else if (mem_req_valid_o) begin
                lock_q <= 1'b1;
                held_q <= gnt;
            end
            if (pop) id_rd_q <= ptr_inc(id_rd_q);
            case ({rsp_push, rsp_pop})
                2'b10:   rcnt_q <= rcnt_q + 1'b1;
                2'b01:   rcnt_q <= rcnt_q - 1'b1;
                default: ;
            endcase
            if (rsp_push) rs_wr_q <= ptr_inc(rs_wr_q);
            if (rsp_pop)  rs_rd_q <= ptr_inc(rs_rd_q);
            if (mem_resp_valid_i && rsp_full) resp_lost_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (hs)       id_mem[id_wr_q]  <= gnt;
        if (rsp_push) rsp_mem[rs_wr_q] <= mem_resp_i;
    end

`ifdef STREAM_TO_MEM_ARB_PERF_EN
    logic [31:0] issued_q, stall_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (hs && (issued_q != '1)) issued_q <= issued_q + 1'b1;
            if ((|req_valid_i) && !hs && (stall_q != '1)) stall_q <= stall_q + 1'b1;
        end
    end
    assign perf_issued_o = issued_q;
    assign perf_stall_o  = stall_q;
`else
    assign perf_issued_o = '0;
    assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_stream_to_mem_arb.sv
// Directed bench for stream_to_mem_arb (NumPorts=2, BufDepth=2) with a fixed-latency memory model.
module tb_stream_to_mem_arb;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] req;
    logic [1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0]  resp, mem_resp, perf_issued, perf_stall;
    logic [63:0]  mem_req;
    logic         mem_req_valid, mem_ready, mem_resp_valid, resp_lost;

    logic [8:1]   pv = '0;
    logic [31:0]  pd [1:8];
    logic [3:0]   lat;
    logic         force_en;

    int n_chk = 0;
    int n_err = 0;

`ifdef STREAM_TO_MEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    stream_to_mem_arb dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .resp_o(resp), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .mem_req_o(mem_req), .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_ready),
        .mem_resp_i(mem_resp), .mem_resp_valid_i(mem_resp_valid),
        .resp_lost_o(resp_lost), .perf_issued_o(perf_issued), .perf_stall_o(perf_stall)
    );

    // Memory answers every accepted request after lat cycles with payload[31:0] ^ FFFF0000.
    always @(posedge clk) begin
        pv <= {pv[7:1], mem_req_valid & mem_ready};
        for (int i = 8; i >= 2; i--) pd[i] <= pd[i-1];
        pd[1] <= mem_req[31:0] ^ 32'hFFFF_0000;
    end
    assign mem_resp_valid = force_en | pv[lat];
    assign mem_resp       = pd[lat];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_valid = '0; resp_ready = 2'b11; mem_ready = 1'b1;
        lat = 4'd1; force_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_mvalid", 64'(mem_req_valid), 64'd0);
        chk("rst_rvalid", 64'(resp_valid), 64'd0);
        chk("rst_rready", 64'(req_ready), 64'd1);
        chk("rst_lost",   64'(resp_lost), 64'd0);
        chk("rst_issued", 64'(perf_issued), 64'd0);
        chk("rst_stall",  64'(perf_stall), 64'd0);

        // alternating grants, latency 1
        step; req[63:0] = 64'hA00; req[127:64] = 64'hB00; req_valid = 2'b11; #1;
        chk("t1c0_rdy", 64'(req_ready), 64'd1);
        chk("t1c0_mreq", mem_req, 64'hA00);
        chk("t1c0_rv", 64'(resp_valid), 64'd0);
        step; #1;
        chk("t1c1_rdy", 64'(req_ready), 64'd2);
        chk("t1c1_mreq", mem_req, 64'hB00);
        chk("t1c1_rv", 64'(resp_valid), 64'd1);
        chk("t1c1_resp", 64'(resp), 64'hFFFF_0A00);
        step; #1;
        chk("t1c2_rdy", 64'(req_ready), 64'd1);
        chk("t1c2_rv", 64'(resp_valid), 64'd2);
        chk("t1c2_resp", 64'(resp), 64'hFFFF_0B00);
        step; req_valid = 2'b00; #1;
        chk("t1c3_mvalid", 64'(mem_req_valid), 64'd0);
        chk("t1c3_rv", 64'(resp_valid), 64'd1);
        chk("t1c3_resp", 64'(resp), 64'hFFFF_0A00);

        // grant lock while memory stalls (rr points at port 1)
        step; req[63:0] = 64'hC00; req_valid = 2'b01; mem_ready = 1'b0; #1;
        chk("t2d0_mvalid", 64'(mem_req_valid), 64'd1);
        chk("t2d0_mreq", mem_req, 64'hC00);
        chk("t2d0_rdy", 64'(req_ready), 64'd0);
        step; req[127:64] = 64'hD00; req_valid = 2'b11; #1;
        chk("t2d1_lock", mem_req, 64'hC00);
        step; #1;
        chk("t2d2_lock", mem_req, 64'hC00);
        step; mem_ready = 1'b1; #1;
        chk("t2d3_rdy", 64'(req_ready), 64'd1);
        chk("t2d3_mreq", mem_req, 64'hC00);
        step; req_valid = 2'b10; #1;
        chk("t2d4_mreq", mem_req, 64'hD00);
        chk("t2d4_rdy", 64'(req_ready), 64'd2);
        chk("t2d4_resp", 64'(resp), 64'hFFFF_0C00);
        step; req_valid = 2'b00; #1;
        chk("t2d5_rv", 64'(resp_valid), 64'd2);
        chk("t2d5_resp", 64'(resp), 64'hFFFF_0D00);
        chk("t2d5_stall", 64'(perf_stall), PERF ? 64'd3 : 64'd0);
        chk("t2d5_issued", 64'(perf_issued), PERF ? 64'd5 : 64'd0);
        repeat (6) step;

        // outstanding limit, latency 4
        lat = 4'd4; req[63:0] = 64'hE00; req_valid = 2'b01; #1;
        chk("t3e0_rdy", 64'(req_ready), 64'd1);
        step; #1;
        chk("t3e1_rdy", 64'(req_ready), 64'd1);
        step; #1;
        chk("t3e2_rdy", 64'(req_ready), 64'd0);
        chk("t3e2_mvalid", 64'(mem_req_valid), 64'd0);
        step; #1;
        chk("t3e3_rdy", 64'(req_ready), 64'd0);
        step; #1;
        chk("t3e4_rv", 64'(resp_valid), 64'd1);
        chk("t3e4_resp", 64'(resp), 64'hFFFF_0E00);
        chk("t3e4_rdy", 64'(req_ready), 64'd1);
        step; #1;
        chk("t3e5_rv", 64'(resp_valid), 64'd1);
        chk("t3e5_rdy", 64'(req_ready), 64'd1);
        step; req_valid = 2'b00;
        repeat (6) step;
        chk("t3_stall", 64'(perf_stall), PERF ? 64'd5 : 64'd0);

        // head-of-line blocking
        lat = 4'd1; resp_ready = 2'b10; req[63:0] = 64'hF00; req[127:64] = 64'h1B00;
        req_valid = 2'b01; #1;
        chk("t4f0_rdy", 64'(req_ready), 64'd1);
        step; req_valid = 2'b10; #1;
        chk("t4f1_rdy", 64'(req_ready), 64'd2);
        chk("t4f1_rv", 64'(resp_valid), 64'd1);
        step; req_valid = 2'b00; #1;
        chk("t4f2_rv", 64'(resp_valid), 64'd1);
        chk("t4f2_resp", 64'(resp), 64'hFFFF_0F00);
        step; resp_ready = 2'b11; #1;
        chk("t4f3_rv", 64'(resp_valid), 64'd1);
        chk("t4f3_lost", 64'(resp_lost), 64'd0);
        step; #1;
        chk("t4f4_rv", 64'(resp_valid), 64'd2);
        chk("t4f4_resp", 64'(resp), 64'hFFFF_1B00);
        step; #1;
        chk("t4f5_rv", 64'(resp_valid), 64'd0);
        chk("t4f5_lost", 64'(resp_lost), 64'd0);

        // response while FIFO full -> sticky loss flag
        step; resp_ready = 2'b00; req[63:0] = 64'h1100; req_valid = 2'b01; #1;
        chk("t5g0_rdy", 64'(req_ready), 64'd1);
        step; #1;
        chk("t5g1_rdy", 64'(req_ready), 64'd1);
        step; req_valid = 2'b00; #1;
        chk("t5g2_rv", 64'(resp_valid), 64'd1);
        step; force_en = 1'b1; #1;
        chk("t5g3_lost", 64'(resp_lost), 64'd0);
        step; force_en = 1'b0; #1;
        chk("t5g4_lost", 64'(resp_lost), 64'd1);
        chk("t5g4_rv", 64'(resp_valid), 64'd1);
        chk("t5g4_resp", 64'(resp), 64'hFFFF_1100);
        step; resp_ready = 2'b11; #1;
        chk("t5g5_rv", 64'(resp_valid), 64'd1);
        step; #1;
        chk("t5g6_rv", 64'(resp_valid), 64'd1);
        step; #1;
        chk("t5g7_rv", 64'(resp_valid), 64'd0);
        chk("t5g7_lost", 64'(resp_lost), 64'd1);
        chk("t5g7_issued", 64'(perf_issued), PERF ? 64'd13 : 64'd0);

        // reset with two outstanding; late responses dropped
        step; lat = 4'd4; req[63:0] = 64'h1300; req_valid = 2'b01; #1;
        chk("t6h0_rdy", 64'(req_ready), 64'd1);
        step; #1;
        chk("t6h1_rdy", 64'(req_ready), 64'd1);
        step; req_valid = 2'b00; rst = 1'b1;
        step; rst = 1'b0; #1;
        chk("t6h3_rv", 64'(resp_valid), 64'd0);
        chk("t6h3_lost", 64'(resp_lost), 64'd0);
        chk("t6h3_issued", 64'(perf_issued), 64'd0);
        chk("t6h3_stall", 64'(perf_stall), 64'd0);
        step; #1;
        chk("t6h4_rv", 64'(resp_valid), 64'd0);
        step; #1;
        chk("t6h5_rv", 64'(resp_valid), 64'd0);
        chk("t6h5_lost", 64'(resp_lost), 64'd0);
        step; lat = 4'd1; req[127:64] = 64'h1200; req_valid = 2'b10; #1;
        chk("t6h6_rdy", 64'(req_ready), 64'd2);
        chk("t6h6_mreq", mem_req, 64'h1200);
        step; req_valid = 2'b00; #1;
        chk("t6h7_rv", 64'(resp_valid), 64'd2);
        chk("t6h7_resp", 64'(resp), 64'hFFFF_1200);
        chk("t6h7_issued", 64'(perf_issued), PERF ? 64'd1 : 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
        $finish;
    end
endmodule
